// File: rtl/uaslr_cfg_gen.sv
`default_nettype none
// ============================================================================
// Module   : uaslr_cfg_gen
// Purpose  : uASLR config word source -- LFSR-derived offset, swapped under a
//            quiesce handshake with the core.
// Revision : 1.0
// ============================================================================
module uaslr_cfg_gen #(
  parameter int unsigned          RNG_WIDTH   = 32,
  parameter int unsigned          PERIOD_W    = 16,
  parameter logic [RNG_WIDTH-1:0] LFSR_SEED   = 32'hACE1_2468,
  parameter int unsigned          ACK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en_i,
  input  logic                 rekey_req_i,
  input  logic [PERIOD_W-1:0]  rekey_period_i,
  input  logic                 entropy_i,
  output logic                 quiesce_req_o,
  input  logic                 quiesce_ack_i,
  output logic [RNG_WIDTH-1:0] uASLR_config_o,
  output logic                 busy_o,
  output logic                 rekey_done_o,
  output logic                 rekey_err_o
);

  // Right-shift Galois taps for x^32+x^22+x^2+x+1 (0x8020_0003 at 32 bits)
  localparam logic [RNG_WIDTH-1:0] c_TAPS =
    {1'b1, {(RNG_WIDTH-1){1'b0}}} | RNG_WIDTH'(32'h0020_0003);
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SWAP    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                 state_q;
  logic [RNG_WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [PERIOD_W-1:0]    cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   expire;
  logic [TMO_W-1:0]       tmo_q;
  logic [RNG_WIDTH-1:0]   cfg_q;
  logic [RNG_WIDTH-3:0]   new_off;
  logic                   req_q, busy_q, done_q, err_q;
  logic                   idle;

  assign idle = (state_q == S_IDLE);

  always_comb begin
    lfsr_step    = {1'b0, lfsr_q[RNG_WIDTH-1:1]} ^ (lfsr_q[0] ? c_TAPS : '0);
    lfsr_step[0] = lfsr_step[0] ^ entropy_i;
    lfsr_d       = (lfsr_step == '0) ? LFSR_SEED : lfsr_step;
  end

  // Period counter only runs while idle with nothing queued; it holds while busy.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (idle) begin
      if (!cfg_q[0] || rekey_period_i == '0) begin
        cnt_d = '0;
      end else if (!pending_q) begin
        if (cnt_q >= rekey_period_i - PERIOD_W'(1)) begin
          expire = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
    end
  end

  // Triggers seen in the cycle that launches a transaction are folded into it.
  // An enable mismatch is a level, so it is only evaluated while idle.
  always_comb begin
    pending_d = pending_q;
    if (idle) begin
      if (pending_q) begin
        pending_d = 1'b0;
      end else begin
        pending_d = rekey_req_i | expire | (cfg_en_i != cfg_q[0]);
      end
    end else begin
      pending_d = pending_q | rekey_req_i;
    end
  end

  always_comb begin
    new_off = lfsr_q[RNG_WIDTH-1:2];
    if (new_off == cfg_q[RNG_WIDTH-1:2]) begin
      new_off[0] = ~new_off[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      tmo_q     <= '0;
      cfg_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end
        S_REQ: begin
          if (quiesce_ack_i) begin
            state_q <= S_SWAP;
          end else if (tmo_q == c_TMO_LAST) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_SWAP: begin
          cfg_q   <= {new_off, 1'b0, cfg_en_i};
          req_q   <= 1'b0;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!quiesce_ack_i) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quiesce_req_o  = req_q;
  assign uASLR_config_o = cfg_q;
  assign busy_o         = busy_q;
  assign rekey_done_o   = done_q;
  assign rekey_err_o    = err_q;

endmodule
`default_nettype wire
